// File: rtl/lsu_trigger_ctl.sv
// LSU trigger control: owns tdata1/tdata2 for four triggers, drives match config to the
// datapath, and carries dc3 match results through dc4/dc5 to produce hit/halt pulses.
module lsu_trigger_ctl #(
    parameter int unsigned NTRIG = 4,
    parameter int unsigned TD2_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   csr_wr_valid,
    output logic                   csr_wr_ready,
    input  logic [1:0]             csr_wr_sel,
    input  logic                   csr_wr_field,
    input  logic [31:0]            csr_wr_data,
    input  logic [1:0]             csr_rd_sel,
    input  logic                   csr_rd_field,
    output logic [31:0]            csr_rd_data,
    output logic [NTRIG-1:0]       trig_load,
    output logic [NTRIG-1:0]       trig_store,
    output logic [NTRIG-1:0]       trig_select,
    output logic [NTRIG-1:0]       trig_match,
    output logic [NTRIG*TD2_W-1:0] trig_tdata2,
    input  logic [NTRIG-1:0]       lsu_trigger_match_dc3,
    input  logic                   flush_dc4,
    output logic [NTRIG-1:0]       trigger_hit_dc5,
    output logic                   trigger_halt_dc5
);

    logic [31:0]      tdata1_q [NTRIG];
    logic [31:0]      tdata1_d [NTRIG];
    logic [TD2_W-1:0] tdata2_q [NTRIG];
    logic [TD2_W-1:0] tdata2_d [NTRIG];

    logic [NTRIG-1:0] dc4_m_q, dc4_m_d, dc5_m_q, dc5_m_d;
    logic             dc4_v_q, dc4_v_d, dc5_v_q, dc5_v_d;

    logic [NTRIG-1:0] en, chain, action, h;
    logic             wr_fire, both;

    always_comb begin
        en     = '0;
        chain  = '0;
        action = '0;
        for (int unsigned i = 0; i < NTRIG; i++) begin
            en[i]     = tdata1_q[i][7];
            chain[i]  = tdata1_q[i][4];
            action[i] = tdata1_q[i][5];
        end

        // Chained pair fires only when both halves matched; otherwise neither reports.
        h    = dc5_v_q ? dc5_m_q : '0;
        both = 1'b0;
        for (int unsigned e = 0; e < NTRIG; e += 2) begin
            if (chain[e]) begin
                both     = h[e] & h[e+1];
                h[e]     = both;
                h[e+1]   = both;
            end
        end

        csr_wr_ready = ~rst & ~(dc4_v_q & |dc4_m_q) & ~(dc5_v_q & |dc5_m_q);
        wr_fire      = csr_wr_valid & csr_wr_ready;

        for (int unsigned i = 0; i < NTRIG; i++) begin
            tdata1_d[i] = tdata1_q[i];
            tdata2_d[i] = tdata2_q[i];
            if (h[i]) begin
                tdata1_d[i][6] = 1'b1;
            end
            if (wr_fire && csr_wr_sel == 2'(i)) begin
                if (csr_wr_field) begin
                    tdata2_d[i] = csr_wr_data[TD2_W-1:0];
                end else begin
                    // Chain is RAZ/WI on odd triggers; upper bits are never stored.
                    tdata1_d[i] = csr_wr_data & ((i % 2 == 1) ? 32'h0000_00EF : 32'h0000_00FF);
                end
            end
        end

        dc4_m_d = lsu_trigger_match_dc3 & en;
        dc4_v_d = 1'b1;
        dc5_m_d = flush_dc4 ? '0 : dc4_m_q;
        dc5_v_d = dc4_v_q & ~flush_dc4;

        trig_load   = '0;
        trig_store  = '0;
        trig_select = '0;
        trig_match  = '0;
        trig_tdata2 = '0;
        for (int unsigned i = 0; i < NTRIG; i++) begin
            trig_load[i]   = ~rst & en[i] & tdata1_q[i][0];
            trig_store[i]  = ~rst & en[i] & tdata1_q[i][1];
            trig_select[i] = ~rst & tdata1_q[i][2];
            trig_match[i]  = ~rst & tdata1_q[i][3];
            trig_tdata2[i*TD2_W +: TD2_W] = rst ? '0 : tdata2_q[i];
        end

        trigger_hit_dc5  = rst ? '0 : h;
        trigger_halt_dc5 = ~rst & |(h & action);

        if (rst) begin
            csr_rd_data = '0;
        end else if (csr_rd_field) begin
            csr_rd_data = tdata2_q[csr_rd_sel];
        end else begin
            csr_rd_data = tdata1_q[csr_rd_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NTRIG; i++) begin
                tdata1_q[i] <= '0;
                tdata2_q[i] <= '0;
            end
            dc4_m_q <= '0;
            dc4_v_q <= 1'b0;
            dc5_m_q <= '0;
            dc5_v_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NTRIG; i++) begin
                tdata1_q[i] <= tdata1_d[i];
                tdata2_q[i] <= tdata2_d[i];
            end
            dc4_m_q <= dc4_m_d;
            dc4_v_q <= dc4_v_d;
            dc5_m_q <= dc5_m_d;
            dc5_v_q <= dc5_v_d;
        end
    end

endmodule

// File: tb/tb_lsu_trigger_ctl.sv
// Scoreboard bench for lsu_trigger_ctl: stimulus queues expected dc5 hit/halt per issued
// dc3 vector; a negedge monitor compares them and flags any unexpected pulse.
module tb_lsu_trigger_ctl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         csr_wr_valid = 1'b0;
    logic         csr_wr_ready;
    logic [1:0]   csr_wr_sel = '0;
    logic         csr_wr_field = 1'b0;
    logic [31:0]  csr_wr_data = '0;
    logic [1:0]   csr_rd_sel = '0;
    logic         csr_rd_field = 1'b0;
    logic [31:0]  csr_rd_data;
    logic [3:0]   trig_load, trig_store, trig_select, trig_match;
    logic [127:0] trig_tdata2;
    logic [3:0]   match_dc3 = '0;
    logic         flush_dc4 = 1'b0;
    logic [3:0]   trigger_hit_dc5;
    logic         trigger_halt_dc5;

    lsu_trigger_ctl #(.NTRIG(4), .TD2_W(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .csr_wr_valid          (csr_wr_valid),
        .csr_wr_ready          (csr_wr_ready),
        .csr_wr_sel            (csr_wr_sel),
        .csr_wr_field          (csr_wr_field),
        .csr_wr_data           (csr_wr_data),
        .csr_rd_sel            (csr_rd_sel),
        .csr_rd_field          (csr_rd_field),
        .csr_rd_data           (csr_rd_data),
        .trig_load             (trig_load),
        .trig_store            (trig_store),
        .trig_select           (trig_select),
        .trig_match            (trig_match),
        .trig_tdata2           (trig_tdata2),
        .lsu_trigger_match_dc3 (match_dc3),
        .flush_dc4             (flush_dc4),
        .trigger_hit_dc5       (trigger_hit_dc5),
        .trigger_halt_dc5      (trigger_halt_dc5)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [3:0]  hit;
        logic        halt;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the entry due this cycle, otherwise the outputs must be idle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("dc5_hit", {124'b0, trigger_hit_dc5}, {124'b0, e.hit});
            chk("dc5_halt", {127'b0, trigger_halt_dc5}, {127'b0, e.halt});
        end else if (trigger_hit_dc5 != '0 || trigger_halt_dc5) begin
            chk("unexpected_pulse", {123'b0, trigger_halt_dc5, trigger_hit_dc5}, '0);
        end
    end

    task automatic push_exp(input logic [3:0] eh, input logic ehalt);
        exp_t e;
        e.due  = cyc + 2;
        e.hit  = eh;
        e.halt = ehalt;
        sb.push_back(e);
    endtask

    // Called #1 after a posedge; presents one dc3 vector for one cycle.
    task automatic dc3(input logic [3:0] m, input logic [3:0] eh, input logic ehalt);
        match_dc3 = m;
        push_exp(eh, ehalt);
        @(posedge clk); #1;
        match_dc3 = '0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [1:0] sel, input logic f, input logic [31:0] d);
        int unsigned n;
        n = 0;
        csr_wr_valid = 1'b1;
        csr_wr_sel   = sel;
        csr_wr_field = f;
        csr_wr_data  = d;
        @(negedge clk);
        while (!csr_wr_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("wr_accept", {127'b0, csr_wr_ready}, 128'd1);
        @(posedge clk); #1;
        csr_wr_valid = 1'b0;
    endtask

    task automatic csr_rd(input string name, input logic [1:0] sel, input logic f,
                          input logic [31:0] exp);
        csr_rd_sel   = sel;
        csr_rd_field = f;
        #1;
        chk(name, {96'b0, csr_rd_data}, {96'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a pending write request
        rst          = 1'b1;
        csr_wr_valid = 1'b1;
        csr_wr_sel   = 2'd1;
        csr_wr_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", {127'b0, csr_wr_ready}, '0);
            chk("rst_cfg", {112'b0, trig_load, trig_store, trig_select, trig_match}, '0);
            chk("rst_tdata2", trig_tdata2, '0);
        end
        @(posedge clk); #1;
        rst          = 1'b0;
        csr_wr_valid = 1'b0;
        chk("post_rst_cfg", {112'b0, trig_load, trig_store, trig_select, trig_match}, '0);
        for (int i = 0; i < 4; i++) begin
            csr_rd("rst_td1", 2'(i), 1'b0, 32'h0);
            csr_rd("rst_td2", 2'(i), 1'b1, 32'h0);
        end

        // Single trigger store match
        csr_wr(2'd1, 1'b1, 32'h8000_1000);
        csr_wr(2'd1, 1'b0, 32'h0000_0083);
        chk("store_en", {124'b0, trig_store}, 128'h2);
        chk("load_en", {124'b0, trig_load}, 128'h2);
        chk("tdata2_1", {96'b0, trig_tdata2[63:32]}, 128'h8000_1000);
        dc3(4'b0010, 4'b0010, 1'b0);
        idle(3);
        csr_rd("td1_1_hit", 2'd1, 1'b0, 32'hC3);

        // Chain 0->1, odd chain bit read-as-zero
        csr_wr(2'd0, 1'b0, 32'h90);
        csr_wr(2'd1, 1'b0, 32'h80);
        csr_rd("td1_0", 2'd0, 1'b0, 32'h90);
        csr_rd("td1_1_clr", 2'd1, 1'b0, 32'h80);
        dc3(4'b0001, 4'b0000, 1'b0);
        dc3(4'b0011, 4'b0011, 1'b0);
        idle(3);
        csr_rd("td1_0_hit", 2'd0, 1'b0, 32'hD0);
        csr_rd("td1_1_chain", 2'd1, 1'b0, 32'hC0);
        csr_wr(2'd1, 1'b0, 32'h00);
        dc3(4'b0011, 4'b0000, 1'b0);
        idle(3);

        // Flush in dc4 kills the match
        csr_wr(2'd2, 1'b0, 32'h80);
        match_dc3 = 4'b0100;
        push_exp(4'b0000, 1'b0);
        @(posedge clk); #1;
        match_dc3 = '0;
        flush_dc4 = 1'b1;
        @(posedge clk); #1;
        flush_dc4 = 1'b0;
        idle(3);
        csr_rd("td1_2_flush", 2'd2, 1'b0, 32'h80);
        dc3(4'b0100, 4'b0100, 1'b0);
        idle(3);
        csr_rd("td1_2_hit", 2'd2, 1'b0, 32'hC0);

        // Halt action, back-to-back pulses
        csr_wr(2'd3, 1'b0, 32'hB0);
        csr_rd("td1_3", 2'd3, 1'b0, 32'hA0);
        dc3(4'b1000, 4'b1000, 1'b1);
        dc3(4'b1100, 4'b1100, 1'b1);
        idle(3);
        csr_rd("td1_3_hit", 2'd3, 1'b0, 32'hE0);

        // Write stalled while a nonzero match is in flight
        match_dc3 = 4'b0100;
        push_exp(4'b0100, 1'b0);
        @(posedge clk); #1;
        match_dc3    = '0;
        csr_wr_valid = 1'b1;
        csr_wr_sel   = 2'd2;
        csr_wr_field = 1'b1;
        csr_wr_data  = 32'h1234_5678;
        @(negedge clk);
        chk("hs_ready_t1", {127'b0, csr_wr_ready}, '0);
        @(negedge clk);
        chk("hs_ready_t2", {127'b0, csr_wr_ready}, '0);
        @(negedge clk);
        chk("hs_ready_t3", {127'b0, csr_wr_ready}, 128'd1);
        @(posedge clk); #1;
        csr_wr_valid = 1'b0;
        chk("hs_tdata2_2", {96'b0, trig_tdata2[95:64]}, 128'h1234_5678);
        idle(5);

        chk("sb_drained", 128'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
